vga_scanout: RTL and testbench

- Downstream stage of the graphics ASIC: consumes the `color` / `pixel_address` stream produced by the renderer's Control and drives the `VGA_ready` input back to it.
- Commits renderer writes into an external dual-port 640x480x3 frame buffer, gated to vertical blanking so frames never tear.
- Scans the frame buffer out as 640x480@60 Hz VGA from a 50 MHz clock (25 MHz pixel enable), generating the sync signals.
- Emits a one-cycle `frame_start` pulse so the top level can latch its shadow position/score buffers once per frame.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_scanout_if.sv | 24 ++
 rtl/vga_timing_gen.sv | 71 +++++++
 rtl/vga_scanout.sv | 149 ++++++++++++++
 tb/tb_vga_scanout.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived constants and datapath types for the scanout block.
package vga_timing_pkg;

  localparam int H_VISIBLE   = 640;
  localparam int H_FP        = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BP        = 48;
  localparam int V_VISIBLE   = 480;
  localparam int V_FP        = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 33;
  localparam int GUARD_LINES = 1;

  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START  = H_VISIBLE + H_FP;
  localparam int HS_END    = HS_START + H_SYNC - 1;
  localparam int VS_START  = V_VISIBLE + V_FP;
  localparam int VS_END    = VS_START + V_SYNC - 1;
  localparam int FB_PIXELS = H_VISIBLE * V_VISIBLE;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 19;

  typedef logic [2:0]        color_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Renderer stream plus external dual-port frame buffer bus; master is the scanout block.
interface vga_scanout_if;
  import vga_timing_pkg::color_t;
  import vga_timing_pkg::addr_t;

  color_t color;
  addr_t  pixel_address;
  logic   VGA_ready;
  logic   fb_wr_en;
  addr_t  fb_wr_addr;
  color_t fb_wr_data;
  addr_t  fb_rd_addr;
  color_t fb_rd_data;

  modport master (
    input  color, pixel_address, fb_rd_data,
    output VGA_ready, fb_wr_en, fb_wr_addr, fb_wr_data, fb_rd_addr
  );

  modport slave (
    output color, pixel_address, fb_rd_data,
    input  VGA_ready, fb_wr_en, fb_wr_addr, fb_wr_data, fb_rd_addr
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider and h/v raster counters with stage-0 sync/active decode.
module vga_timing_gen
  import vga_timing_pkg::cnt_t;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic hs_raw,
  output logic vs_raw,
  output logic active,
  output logic frame_wrap
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic pix_en_d, pix_en_q;
  cnt_t h_cnt_d, h_cnt_q;
  cnt_t v_cnt_d, v_cnt_q;
  logic h_last, v_last;

  always_comb begin
    h_last   = (h_cnt_q == cnt_t'(H_TOTAL - 1));
    v_last   = (v_cnt_q == cnt_t'(V_TOTAL - 1));
    pix_en_d = ~pix_en_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    if (pix_en_q) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + cnt_t'(1);
      if (h_last)
        v_cnt_d = v_last ? '0 : v_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      pix_en_q <= pix_en_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
    end
  end

  assign pix_en     = pix_en_q;
  assign h_cnt      = h_cnt_q;
  assign v_cnt      = v_cnt_q;
  assign hs_raw     = (h_cnt_q >= cnt_t'(HS_START)) && (h_cnt_q <= cnt_t'(HS_END));
  assign vs_raw     = (v_cnt_q >= cnt_t'(VS_START)) && (v_cnt_q <= cnt_t'(VS_END));
  assign active     = (h_cnt_q < cnt_t'(H_VISIBLE)) && (v_cnt_q < cnt_t'(V_VISIBLE));
  // True on the tick that takes the raster from the last pixel back to (0,0).
  assign frame_wrap = pix_en_q && h_last && v_last;

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: read pipeline, vblank-gated frame buffer write path and registered VGA outputs.
module vga_scanout
  import vga_timing_pkg::color_t;
  import vga_timing_pkg::cnt_t;
  import vga_timing_pkg::addr_t;
#(
  parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int GUARD_LINES = vga_timing_pkg::GUARD_LINES
) (
  input  logic          clk,
  input  logic          rst,
  vga_scanout_if.master bus,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_red,
  output logic          vga_green,
  output logic          vga_blue,
  output logic          frame_start
);

  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int WIN_FIRST = V_VISIBLE;
  localparam int WIN_LAST  = V_TOTAL - 1 - GUARD_LINES;
  localparam int FB_PIXELS = H_VISIBLE * V_VISIBLE;

  logic pix_en, hs_raw, vs_raw, active, frame_wrap;
  cnt_t h_cnt, v_cnt;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_tg (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .active     (active),
    .frame_wrap (frame_wrap)
  );

  // y*640 as two shifts at the native width; generic multiply for other geometries.
  addr_t rd_addr_calc;
  generate
    if (H_VISIBLE == 640) begin : g_shift
      assign rd_addr_calc = (addr_t'(v_cnt) << 9) + (addr_t'(v_cnt) << 7) + addr_t'(h_cnt);
    end else begin : g_mul
      assign rd_addr_calc = addr_t'(v_cnt) * addr_t'(H_VISIBLE) + addr_t'(h_cnt);
    end
  endgenerate

  // Stage 1 registers flags alongside the read address; the output
  // register then meets the RAM data one tick later (second delay).
  addr_t  rd_addr_d,  rd_addr_q;
  logic   hs_d1_d,    hs_d1_q;
  logic   vs_d1_d,    vs_d1_q;
  logic   act_d1_d,   act_d1_q;
  logic   hsync_d,    hsync_q;
  logic   vsync_d,    vsync_q;
  color_t rgb_d,      rgb_q;
  logic   ready_d,    ready_q;
  logic   wr_en_d,    wr_en_q;
  addr_t  wr_addr_d,  wr_addr_q;
  color_t wr_data_d,  wr_data_q;
  logic   fstart_d,   fstart_q;

  always_comb begin
    rd_addr_d = rd_addr_q;
    hs_d1_d   = hs_d1_q;
    vs_d1_d   = vs_d1_q;
    act_d1_d  = act_d1_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;
    if (pix_en) begin
      rd_addr_d = rd_addr_calc;
      hs_d1_d   = hs_raw;
      vs_d1_d   = vs_raw;
      act_d1_d  = active;
      hsync_d   = ~hs_d1_q;
      vsync_d   = ~vs_d1_q;
      rgb_d     = act_d1_q ? bus.fb_rd_data : '0;
    end
    // Write window lives entirely in vertical blanking, so reads never collide.
    ready_d   = (v_cnt >= cnt_t'(WIN_FIRST)) && (v_cnt <= cnt_t'(WIN_LAST));
    wr_en_d   = ready_q && (bus.pixel_address < addr_t'(FB_PIXELS));
    wr_addr_d = bus.pixel_address;
    wr_data_d = bus.color;
    fstart_d  = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q <= '0;
      hs_d1_q   <= 1'b0;
      vs_d1_q   <= 1'b0;
      act_d1_q  <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fstart_q  <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      hs_d1_q   <= hs_d1_d;
      vs_d1_q   <= vs_d1_d;
      act_d1_q  <= act_d1_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fstart_q  <= fstart_d;
    end
  end

  assign bus.VGA_ready  = ready_q;
  assign bus.fb_wr_en   = wr_en_q;
  assign bus.fb_wr_addr = wr_addr_q;
  assign bus.fb_wr_data = wr_data_q;
  assign bus.fb_rd_addr = rd_addr_q;
  assign vga_hsync      = hsync_q;
  assign vga_vsync      = vsync_q;
  assign vga_red        = rgb_q[2];
  assign vga_green      = rgb_q[1];
  assign vga_blue       = rgb_q[0];
  assign frame_start    = fstart_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster geometry with a registered RAM model.
module tb_vga_scanout;
  import vga_timing_pkg::*;

  localparam int HV = 16, HFP = 2, HSY = 4, HBP = 2;
  localparam int VV = 12, VFP = 2, VSY = 2, VBP = 3, GL = 1;
  localparam int HT  = HV + HFP + HSY + HBP;
  localparam int VT  = VV + VFP + VSY + VBP;
  localparam int FT  = HT * VT;
  localparam int FBP = HV * VV;
  localparam int HSS = HV + HFP, HSE = HSS + HSY - 1;
  localparam int VSS = VV + VFP, VSE = VSS + VSY - 1;

  typedef struct packed {
    logic   en;
    addr_t  a;
    color_t d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  logic vga_hsync, vga_vsync, vga_red, vga_green, vga_blue, frame_start;

  vga_scanout_if bus();

  vga_scanout #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .GUARD_LINES(GL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_red     (vga_red),
    .vga_green   (vga_green),
    .vga_blue    (vga_blue),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  color_t ram     [512];
  color_t ref_mem [512];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) ram[i] <= color_t'(i * 5 + 1);
    end else if (bus.fb_wr_en) begin
      ram[bus.fb_wr_addr[8:0]] <= bus.fb_wr_data;
    end
    bus.fb_rd_data <= ram[bus.fb_rd_addr[8:0]];
  end

  int  ncmp = 0;
  int  nfail = 0;
  int  k = 0;
  wr_t wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h at clk %0d", tag, obs, exp, k);
    end
  endtask

  function automatic logic in_win(input int n);
    int v;
    v = (n % FT) / HT;
    return (v >= VV) && (v <= VT - 1 - GL);
  endfunction

  function automatic logic ready_exp(input int kk);
    return (kk >= 1) && in_win((kk - 1) / 2);
  endfunction

  function automatic addr_t stim_addr(input int kk);
    addr_t pat [6];
    pat = '{addr_t'(100), addr_t'(FBP), addr_t'(FBP - 1), addr_t'(7), 19'h7FFFF, addr_t'(50)};
    return pat[kk % 6];
  endfunction

  task automatic drive_and_push();
    addr_t  a;
    color_t c;
    wr_t    e;
    a = stim_addr(k);
    c = color_t'(k);
    bus.pixel_address = a;
    bus.color = c;
    e.en = ready_exp(k) && (a < addr_t'(FBP));
    e.a = a;
    e.d = c;
    wq.push_back(e);
  endtask

  task automatic step();
    wr_t    e;
    int     p, h, v, n;
    logic   act;
    color_t exp_rgb;
    logic   exp_hs, exp_vs;
    @(posedge clk);
    k++;
    #1;
    if (wq.size() == 0) begin
      chk("wr_queue_nonempty", 32'(wq.size()), 32'd1);
    end else begin
      e = wq.pop_front();
      chk("wr_en", 32'(bus.fb_wr_en), 32'(e.en));
      if (e.en) begin
        chk("wr_addr", 32'(bus.fb_wr_addr), 32'(e.a));
        chk("wr_data", 32'(bus.fb_wr_data), 32'(e.d));
        ref_mem[e.a[8:0]] = e.d;
      end
    end
    exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1;
    if (k >= 4) begin
      p = (k / 2 - 2) % FT;
      h = p % HT; v = p / HT;
      act = (h < HV) && (v < VV);
      exp_rgb = act ? ref_mem[v * HV + h] : 3'b000;
      exp_hs = !((h >= HSS) && (h <= HSE));
      exp_vs = !((v >= VSS) && (v <= VSE));
    end
    chk("rgb", 32'({vga_red, vga_green, vga_blue}), 32'(exp_rgb));
    chk("hsync", 32'(vga_hsync), 32'(exp_hs));
    chk("vsync", 32'(vga_vsync), 32'(exp_vs));
    if (k >= 2) begin
      n = (k / 2 - 1) % FT;
      h = n % HT; v = n / HT;
      if ((h < HV) && (v < VV)) chk("rd_addr", 32'(bus.fb_rd_addr), 32'(v * HV + h));
    end
    chk("ready", 32'(bus.VGA_ready), 32'(ready_exp(k)));
    chk("frame_start", 32'(frame_start), 32'((k > 0) && (k % (2 * FT) == 0)));
    drive_and_push();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    wq.delete();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      chk("rst_hsync", 32'(vga_hsync), 32'd1);
      chk("rst_vsync", 32'(vga_vsync), 32'd1);
      chk("rst_rgb", 32'({vga_red, vga_green, vga_blue}), 32'd0);
      chk("rst_ready", 32'(bus.VGA_ready), 32'd0);
      chk("rst_wr_en", 32'(bus.fb_wr_en), 32'd0);
      chk("rst_wr_addr", 32'(bus.fb_wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bus.fb_wr_data), 32'd0);
      chk("rst_rd_addr", 32'(bus.fb_rd_addr), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
    end
    preload = 1'b0;
    rst = 1'b0;
    k = 0;
    drive_and_push();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = color_t'(i * 5 + 1);
    bus.pixel_address = '0;
    bus.color = '0;
    do_reset(3);

    // Two full frames plus margin: syncs, window edges, frame_start, write gating.
    repeat (4 * FT + 40) step();

    // Walk to mid-visible line 6 of the current frame, then a single-clock reset.
    for (int i = 0; i < 2 * FT && (((k / 2) % FT) / HT) != 6; i++) step();
    repeat (11) step();
    do_reset(1);

    // Timing restarts from scratch after the mid-frame reset.
    repeat (2 * FT + 60) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
